gan_disc_scheduler: RTL and testbench
=====================================

# gan_disc_scheduler

Shares one `simple_discriminator` instance between two requesters: the real-sample path and the generator (fake) path. It performs round-robin arbitration, captures the winner's 3x3 sample, issues it to the discriminator and waits for the score. It then routes the score back to the owning requester and keeps per-source completion counts. A timeout guard prevents a hung discriminator from locking out both sources.

## Interface
Parameters:
- DATA_WIDTH, 16, sample/score width (Q8.8)
- INPUT_SIZE, 9, elements per sample
- TIMEOUT_CYCLES, 255, max cycles in WAIT before forced completion (must be ≥2)
- CNT_WIDTH, 16, completion counter width

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- real_req  in  1  real-path request; held with real_data until real_ack
- real_data  in  INPUT_SIZE*DATA_WIDTH  flattened sample, element i at [i*DATA_WIDTH +: DATA_WIDTH]
- real_ack  out  1  one-cycle pulse: real request accepted
- real_score_valid  out  1  one-cycle pulse: real_score valid
- real_score  out  DATA_WIDTH  score for real request
- fake_req, fake_data, fake_ack, fake_score_valid, fake_score: identical to the real_* ports, for the generator path
- d_data  out  INPUT_SIZE*DATA_WIDTH  sample to discriminator data_in (same packing)
- d_valid  out  1  one-cycle pulse to discriminator valid_in
- d_done  in  1  discriminator done/valid_out pulse
- d_score  in  DATA_WIDTH  discriminator disc_out, sampled when d_done=1
- busy  out  1  state != IDLE
- timeout_err  out  1  sticky: a WAIT timed out
- clear_cnt  in  1  synchronous clear of counters and timeout_err
- real_cnt, fake_cnt  out  CNT_WIDTH  completed jobs per source, saturating

## Operation
- FSM states: IDLE → ISSUE → WAIT → RESP → IDLE.
- **IDLE**
  - If any req is high, select the winner.
  - A single requester wins directly.
  - If both are high, the source not served last wins. The last-served pointer resets to "fake", so real wins the first tie.
  - Capture the winner's data into d_data (held until the next capture) and record the owner.
  - Go to ISSUE.
- **ISSUE** (one cycle)
  - The owner's ack=1 and d_valid=1.
  - Clear the wait counter and go to WAIT.
- **WAIT**
  - If d_done=1: capture d_score and go to RESP.
  - Else if the wait counter equals TIMEOUT_CYCLES-1: capture score 0, set timeout_err and go to RESP.
  - Else increment the wait counter.
  - If d_done arrives on the final timeout cycle, d_done wins and no error is raised.
- **RESP** (one cycle)
  - The owner's score_valid=1 with the captured score. The other source's score_valid stays 0.
  - Increment the owner's counter, saturating at all-ones. Timed-out jobs also count.
  - Update the last-served pointer and go to IDLE.
- d_done outside WAIT is ignored.
- A requester keeps req/data stable until it sees ack. req still high in the cycle after ack is a new request.
- clear_cnt zeroes real_cnt, fake_cnt and timeout_err, and wins over a coincident increment or timeout. It does not affect the FSM.
- Reset mid-operation returns the FSM to IDLE immediately. The in-flight job is dropped with no score_valid.

## Timing
- All outputs are registered. Reset values:
  - all ack, score_valid, d_valid, busy and timeout_err = 0
  - scores, d_data and counters = 0
  - last-served pointer = fake
- Request sampled at edge E0 (IDLE) → ack and d_valid high in cycle E0..E1.
- d_done high at edge Ek (WAIT) → score_valid high in cycle Ek..Ek+1 (RESP).
- Minimum spacing from RESP to the next d_valid is 2 cycles (IDLE, ISSUE). This guarantees the discriminator has returned to its idle state.
- Wait counter width is ceil(log2(TIMEOUT_CYCLES)) bits. It never wraps, because the timeout fires at TIMEOUT_CYCLES-1.
- ack, d_valid and score_valid are never high for more than one consecutive cycle.

## Test plan
- Single real request, data element i = 16'h0100*i, model d_done 40 cycles after d_valid with d_score=16'h0080:
  - real_ack and d_valid coincide one cycle after req.
  - d_data matches the request data.
  - real_score_valid carries 16'h0080 one cycle after d_done.
  - real_cnt=1, fake_* stay 0.
- real_req and fake_req held high continuously for 6 jobs: grants alternate real, fake, real…; real_cnt=3 and fake_cnt=3.
- No d_done after d_valid with TIMEOUT_CYCLES=8:
  - score_valid with score 0 exactly 8 WAIT cycles later; timeout_err=1 and stays 1.
  - A subsequent clear_cnt clears timeout_err and the counters.
- d_done on the final timeout cycle: score = d_score and timeout_err stays 0.
- Stray d_done in IDLE and in ISSUE: no score_valid, no counter change.
- rst_n asserted during WAIT:
  - all outputs 0 immediately, busy=0, no score_valid after release.
  - The next fake_req is served, and a later tie goes to real.

Source files
------------

// File: rtl/gan_disc_scheduler.sv
// gan_disc_scheduler: round-robin sharing of one discriminator between the real and fake sample paths
module gan_disc_scheduler #(
  parameter int DATA_WIDTH     = 16,
  parameter int INPUT_SIZE     = 9,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               real_req,
  input  logic [INPUT_SIZE*DATA_WIDTH-1:0]   real_data,
  output logic                               real_ack,
  output logic                               real_score_valid,
  output logic [DATA_WIDTH-1:0]              real_score,
  input  logic                               fake_req,
  input  logic [INPUT_SIZE*DATA_WIDTH-1:0]   fake_data,
  output logic                               fake_ack,
  output logic                               fake_score_valid,
  output logic [DATA_WIDTH-1:0]              fake_score,
  output logic [INPUT_SIZE*DATA_WIDTH-1:0]   d_data,
  output logic                               d_valid,
  input  logic                               d_done,
  input  logic [DATA_WIDTH-1:0]              d_score,
  output logic                               busy,
  output logic                               timeout_err,
  input  logic                               clear_cnt,
  output logic [CNT_WIDTH-1:0]               real_cnt,
  output logic [CNT_WIDTH-1:0]               fake_cnt
);
  localparam int WW = $clog2(TIMEOUT_CYCLES);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t state, state_n;
  logic owner, owner_n, last, timeout;
  logic [WW-1:0] wcnt, wcnt_n;
  logic [DATA_WIDTH-1:0] score_n;
  // next state, arbitration (owner 1 = fake) and wait-counter/timeout evaluation
  always_comb begin
    state_n = state;
    owner_n = owner;
    wcnt_n  = wcnt;
    score_n = '0;
    timeout = 1'b0;
    case (state)
      IDLE: if (real_req || fake_req) begin
        owner_n = (real_req && fake_req) ? ~last : fake_req;
        state_n = ISSUE;
      end
      ISSUE: begin
        wcnt_n  = '0;
        state_n = WAIT;
      end
      WAIT: begin
        timeout = !d_done && (wcnt == WW'(TIMEOUT_CYCLES - 1));
        score_n = d_done ? d_score : '0;
        wcnt_n  = (d_done || timeout) ? wcnt : wcnt + 1'b1;
        state_n = (d_done || timeout) ? RESP : WAIT;
      end
      default: state_n = IDLE;
    endcase
  end
  // state register, captured sample, round-robin pointer and registered one-cycle pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      owner            <= 1'b0;
      last             <= 1'b1;
      wcnt             <= '0;
      d_data           <= '0;
      d_valid          <= 1'b0;
      real_ack         <= 1'b0;
      fake_ack         <= 1'b0;
      real_score_valid <= 1'b0;
      fake_score_valid <= 1'b0;
      real_score       <= '0;
      fake_score       <= '0;
      busy             <= 1'b0;
    end else begin
      state            <= state_n;
      owner            <= owner_n;
      wcnt             <= wcnt_n;
      if (state == IDLE && state_n == ISSUE) d_data <= owner_n ? fake_data : real_data;
      if (state == RESP) last <= owner;
      d_valid          <= state_n == ISSUE;
      real_ack         <= state_n == ISSUE && !owner_n;
      fake_ack         <= state_n == ISSUE && owner_n;
      real_score_valid <= state_n == RESP && !owner_n;
      fake_score_valid <= state_n == RESP && owner_n;
      if (state_n == RESP && !owner_n) real_score <= score_n;
      if (state_n == RESP && owner_n) fake_score <= score_n;
      busy             <= state_n != IDLE;
    end
  end
  // saturating per-source completion counters and sticky timeout flag; clear_cnt has priority
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      real_cnt    <= '0;
      fake_cnt    <= '0;
      timeout_err <= 1'b0;
    end else if (clear_cnt) begin
      real_cnt    <= '0;
      fake_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (timeout) timeout_err <= 1'b1;
      if (state == RESP && !owner && !(&real_cnt)) real_cnt <= real_cnt + 1'b1;
      if (state == RESP && owner && !(&fake_cnt)) fake_cnt <= fake_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_gan_disc_scheduler.sv
// tb_gan_disc_scheduler: directed and randomized jobs checked against a job-level round-robin model
module tb_gan_disc_scheduler;
  localparam int DW = 16, IS = 9, TO = 48, CW = 16, W = DW * IS;
  logic clk = 1'b0, rst_n = 1'b0;
  logic real_req = 1'b0, fake_req = 1'b0, d_done = 1'b0, clear_cnt = 1'b0;
  logic [W-1:0] real_data = '0, fake_data = '0;
  logic [DW-1:0] d_score = '0;
  logic real_ack, fake_ack, real_score_valid, fake_score_valid, d_valid, busy, timeout_err;
  logic [DW-1:0] real_score, fake_score;
  logic [W-1:0] d_data;
  logic [CW-1:0] real_cnt, fake_cnt;
  int checks = 0, errors = 0;
  bit m_last = 1'b1, m_terr = 1'b0;
  int m_rc = 0, m_fc = 0;

  always #5 clk = ~clk;

  gan_disc_scheduler #(.DATA_WIDTH(DW), .INPUT_SIZE(IS), .TIMEOUT_CYCLES(TO), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .real_req(real_req), .real_data(real_data), .real_ack(real_ack),
    .real_score_valid(real_score_valid), .real_score(real_score),
    .fake_req(fake_req), .fake_data(fake_data), .fake_ack(fake_ack),
    .fake_score_valid(fake_score_valid), .fake_score(fake_score),
    .d_data(d_data), .d_valid(d_valid), .d_done(d_done), .d_score(d_score),
    .busy(busy), .timeout_err(timeout_err), .clear_cnt(clear_cnt),
    .real_cnt(real_cnt), .fake_cnt(fake_cnt)
  );

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] rnd_data();
    logic [W-1:0] v;
    for (int i = 0; i < IS; i++) v[i*DW +: DW] = DW'($urandom);
    return v;
  endfunction

  // one complete job: lat = cycles from d_valid to d_done (0 or >TO means no d_done),
  // stray = extra d_done while in ISSUE, clr = clear_cnt coincident with the counter update
  task automatic job(input bit rq, input bit fq, input int lat, input logic [DW-1:0] sc,
                     input bit stray, input bit clr);
    bit w;
    int jx;
    logic [W-1:0] xd;
    logic [DW-1:0] xs;
    real_req = rq;
    fake_req = fq;
    d_score  = sc;
    w  = (rq && fq) ? !m_last : fq;
    xd = w ? fake_data : real_data;
    @(negedge clk);
    chk("real_ack", real_ack, !w);
    chk("fake_ack", fake_ack, w);
    chk("d_valid", d_valid, 1'b1);
    chk("d_data", d_data, xd);
    if (w) fake_data = rnd_data(); else real_data = rnd_data();
    jx = (lat >= 1 && lat <= TO) ? lat + 1 : TO + 1;
    xs = (lat >= 1 && lat <= TO) ? sc : '0;
    d_done = stray;
    for (int j = 1; j < jx; j++) begin
      @(negedge clk);
      d_done = (j == lat);
      chk("wait_quiet", {real_score_valid, fake_score_valid, d_valid, real_ack, fake_ack, busy}, 6'b000001);
    end
    @(negedge clk);
    d_done = 1'b0;
    clear_cnt = clr;
    if (!(lat >= 1 && lat <= TO)) m_terr = 1'b1;
    chk("real_score_valid", real_score_valid, !w);
    chk("fake_score_valid", fake_score_valid, w);
    chk("score", w ? fake_score : real_score, xs);
    chk("timeout_err", timeout_err, m_terr);
    if (w) m_fc++; else m_rc++;
    m_last = w;
    if (clr) begin
      m_rc = 0;
      m_fc = 0;
      m_terr = 1'b0;
    end
    @(negedge clk);
    clear_cnt = 1'b0;
    chk("real_cnt", real_cnt, m_rc);
    chk("fake_cnt", fake_cnt, m_fc);
    chk("timeout_err_after", timeout_err, m_terr);
    chk("busy_idle", {busy, real_score_valid, fake_score_valid}, 3'b000);
  endtask

  task automatic clear();
    real_req = 1'b0;
    fake_req = 1'b0;
    clear_cnt = 1'b1;
    @(negedge clk);
    clear_cnt = 1'b0;
    m_rc = 0;
    m_fc = 0;
    m_terr = 1'b0;
    chk("clr_cnts", {real_cnt, fake_cnt}, '0);
    chk("clr_terr", timeout_err, 1'b0);
  endtask

  task automatic stray_idle();
    real_req = 1'b0;
    fake_req = 1'b0;
    d_done = 1'b1;
    @(negedge clk);
    d_done = 1'b0;
    chk("stray_idle_quiet", {real_score_valid, fake_score_valid, busy, d_valid}, 4'b0000);
    @(negedge clk);
    chk("stray_idle_quiet2", {real_score_valid, fake_score_valid, busy}, 3'b000);
    chk("stray_idle_cnt", {real_cnt, fake_cnt}, {CW'(m_rc), CW'(m_fc)});
  endtask

  initial begin
    int k;
    for (int i = 0; i < IS; i++) real_data[i*DW +: DW] = DW'(16'h0100 * i);
    repeat (2) @(negedge clk);
    chk("reset_pulses", {real_ack, fake_ack, real_score_valid, fake_score_valid, d_valid, busy, timeout_err}, '0);
    chk("reset_values", {real_score, fake_score, real_cnt, fake_cnt}, '0);
    chk("reset_d_data", d_data, '0);
    rst_n = 1'b1;
    @(negedge clk);
    job(1'b1, 1'b0, 40, 16'h0080, 1'b0, 1'b0);
    chk("single_fake_quiet", {fake_cnt, fake_score}, '0);
    clear();
    for (int n = 0; n < 6; n++) job(1'b1, 1'b1, $urandom_range(1, 6), DW'($urandom), 1'b0, 1'b0);
    chk("tie_counts", {real_cnt, fake_cnt}, {16'd3, 16'd3});
    job(1'b1, 1'b0, 0, 16'h1234, 1'b0, 1'b0);
    job(1'b0, 1'b1, 5, 16'h0222, 1'b0, 1'b0);
    chk("timeout_sticky", timeout_err, 1'b1);
    clear();
    job(1'b0, 1'b1, TO, 16'h0abc, 1'b0, 1'b0);
    chk("final_cycle_no_err", timeout_err, 1'b0);
    stray_idle();
    job(1'b1, 1'b0, 4, 16'h0333, 1'b1, 1'b0);
    job(1'b0, 1'b1, 3, 16'h0444, 1'b0, 1'b1);
    job(1'b1, 1'b0, 3, 16'h0101, 1'b0, 1'b0);
    real_req = 1'b1;
    fake_req = 1'b0;
    @(negedge clk);
    chk("rst_job_ack", real_ack, 1'b1);
    real_req = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_job_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("rst_async_pulses", {real_ack, fake_ack, real_score_valid, fake_score_valid, d_valid, busy, timeout_err}, '0);
    chk("rst_async_values", {real_score, fake_score, real_cnt, fake_cnt}, '0);
    chk("rst_async_d_data", d_data, '0);
    m_last = 1'b1;
    m_rc = 0;
    m_fc = 0;
    m_terr = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (TO + 4) begin
      @(negedge clk);
      chk("rst_no_score", {real_score_valid, fake_score_valid, busy}, 3'b000);
    end
    job(1'b1, 1'b1, 2, 16'h0555, 1'b0, 1'b0);
    job(1'b0, 1'b1, 2, 16'h0666, 1'b0, 1'b0);
    job(1'b1, 1'b1, 2, 16'h0777, 1'b0, 1'b0);
    for (int n = 0; n < 30; n++) begin
      k = $urandom_range(1, 3);
      job(k[0], k[1], $urandom_range(0, TO + 2), DW'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
